// File: rtl/shift_div_pkg.sv
// Shared definitions for the serial restoring divider.
// Holds widths, state encodings and the FSM state type.
package shift_div_pkg;

    localparam int DIVIDEND_WIDTH = 16;
    localparam int CNT_WIDTH      = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value on the edge that retires the final quotient bit.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT =
        CNT_WIDTH'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports: pr/next_bit/divisor in; new_pr and q_bit out.
module div_step #(
    parameter int D_WIDTH = 8
) (
    input  logic [D_WIDTH:0]   pr,
    input  logic               next_bit,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [D_WIDTH:0]   new_pr,
    output logic               q_bit
);

    logic [D_WIDTH:0]   pr_shift;
    logic [D_WIDTH+1:0] trial;
    logic               pr_msb_unused;

    // The partial remainder msb is shifted out on every step.
    assign pr_msb_unused = pr[D_WIDTH];

    assign pr_shift = {pr[D_WIDTH-1:0], next_bit};

    // One extra bit keeps the sign of the trial subtraction.
    assign trial = {1'b0, pr_shift} - {2'b00, divisor};

    assign q_bit  = ~trial[D_WIDTH+1];
    assign new_pr = q_bit ? trial[D_WIDTH:0] : pr_shift;

endmodule

// File: rtl/shift_div16.sv
// Serial restoring divider: 16-bit dividend, one quotient bit per clock.
// Ports: clk, rst (sync, active high), start, dividend, divisor in;
// busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
module shift_div16
    import shift_div_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0]        divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0]        remainder,
    output logic                      div_by_zero
);

    state_t state;
    state_t next_state;

    logic [CNT_WIDTH-1:0]      cnt;
    logic [DIVIDEND_WIDTH-1:0] dsr;
    logic [D_WIDTH-1:0]        dvs;
    logic [D_WIDTH:0]          pr;

    logic [D_WIDTH:0] new_pr;
    logic             q_bit;
    logic             last;
    logic             accept;

    div_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .pr       (pr),
        .next_bit (dsr[DIVIDEND_WIDTH-1]),
        .divisor  (dvs),
        .new_pr   (new_pr),
        .q_bit    (q_bit)
    );

    assign last   = (cnt == LAST_CNT);
    assign accept = (state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Quotient bits enter the dividend register from the bottom as
    // dividend bits leave from the top, so one register serves both.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dsr         <= '0;
            dvs         <= '0;
            pr          <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dsr <= dividend;
            dvs <= divisor;
            pr  <= '0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            pr  <= new_pr;
            dsr <= {dsr[DIVIDEND_WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (last) begin
                // A zero divisor still runs the full iteration so the
                // latency is fixed; its raw result is replaced here.
                if (dvs == '0) begin
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= {dsr[DIVIDEND_WIDTH-2:0], q_bit};
                    remainder   <= new_pr[D_WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_div16.sv
// Directed bench for shift_div16 at D_WIDTH 8 and 16.
// Expected results are queued at start and checked on done.
module tb_shift_div16;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        a_start;
    logic [15:0] a_dividend;
    logic [7:0]  a_divisor;
    logic        a_busy;
    logic        a_done;
    logic [15:0] a_quotient;
    logic [7:0]  a_remainder;
    logic        a_dbz;

    logic        b_start;
    logic [15:0] b_dividend;
    logic [15:0] b_divisor;
    logic        b_busy;
    logic        b_done;
    logic [15:0] b_quotient;
    logic [15:0] b_remainder;
    logic        b_dbz;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    logic [15:0] held_q;
    logic [15:0] held_r;
    logic        held_z;
    int          busy_len;
    logic        a_prev_done;

    shift_div16 #(.D_WIDTH(8)) u_a (
        .clk         (clk),
        .rst         (rst),
        .start       (a_start),
        .dividend    (a_dividend),
        .divisor     (a_divisor),
        .busy        (a_busy),
        .done        (a_done),
        .quotient    (a_quotient),
        .remainder   (a_remainder),
        .div_by_zero (a_dbz)
    );

    shift_div16 #(.D_WIDTH(16)) u_b (
        .clk         (clk),
        .rst         (rst),
        .start       (b_start),
        .dividend    (b_dividend),
        .divisor     (b_divisor),
        .busy        (b_busy),
        .done        (b_done),
        .quotient    (b_quotient),
        .remainder   (b_remainder),
        .div_by_zero (b_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a,
                                input logic [15:0] b, input int c);
        exp_t e;
        if (b == 16'd0) begin
            e.q = 16'hFFFF;
            e.r = 16'd0;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.cyc = c;
        return e;
    endfunction

    task automatic start_op(input bit sel, input logic [15:0] a,
                            input logic [15:0] b, input bit push);
        if (sel) begin
            b_start = 1'b1; b_dividend = a; b_divisor = b;
        end else begin
            a_start = 1'b1; a_dividend = a; a_divisor = b[7:0];
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
        if (push) begin
            if (sel) sb_b.push_back(mk(a, b, cyc + 16));
            else sb_a.push_back(mk(a, {8'h00, b[7:0]}, cyc + 16));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(sb_a.size() + sb_b.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_q = 16'd0;
            held_r = 16'd0;
            held_z = 1'b0;
            busy_len = 0;
            a_prev_done = 1'b0;
        end else begin
            if (a_busy) begin
                busy_len++;
                chk("a_hold_q", 32'(a_quotient), 32'(held_q));
                chk("a_hold_r", 32'(a_remainder), 32'(held_r));
                chk("a_hold_z", 32'(a_dbz), 32'(held_z));
            end
            if (a_done) begin
                chk("a_done_width", 32'(a_prev_done), 32'd0);
                if (sb_a.size() == 0) begin
                    chk("a_spurious_done", 32'(a_done), 32'd0);
                end else begin
                    e = sb_a.pop_front();
                    chk("a_quot", 32'(a_quotient), 32'(e.q));
                    chk("a_rem", 32'(a_remainder), 32'(e.r));
                    chk("a_dbz", 32'(a_dbz), 32'(e.z));
                    chk("a_latency", 32'(cyc), 32'(e.cyc));
                    chk("a_busy_len", 32'(busy_len), 32'd16);
                    held_q = e.q;
                    held_r = e.r;
                    held_z = e.z;
                end
                busy_len = 0;
            end
            a_prev_done = a_done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_done) begin
            if (sb_b.size() == 0) begin
                chk("b_spurious_done", 32'(b_done), 32'd0);
            end else begin
                e = sb_b.pop_front();
                chk("b_quot", 32'(b_quotient), 32'(e.q));
                chk("b_rem", 32'(b_remainder), 32'(e.r));
                chk("b_dbz", 32'(b_dbz), 32'(e.z));
                chk("b_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_dividend = 16'd0; a_divisor = 8'd0;
        b_start = 1'b0; b_dividend = 16'd0; b_divisor = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_quot", 32'(a_quotient), 32'd0);
        chk("rst_rem", 32'(a_remainder), 32'd0);
        chk("rst_dbz", 32'(a_dbz), 32'd0);
        chk("rst_b_quot", 32'(b_quotient), 32'd0);

        // reset and start together: reset wins
        rst = 1'b1; a_start = 1'b1; a_dividend = 16'd50; a_divisor = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; a_start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_busy", 32'(a_busy), 32'd0);

        start_op(0, 16'd1000, 16'd7, 1);
        chk("busy_after_start", 32'(a_busy), 32'd1);
        drain();

        start_op(0, 16'hFFFF, 16'd1, 1);
        drain();
        start_op(1, 16'hFFFF, 16'hFFFF, 1);
        drain();
        start_op(1, 16'd1000, 16'd7, 1);
        drain();
        start_op(1, 16'd40000, 16'd0, 1);
        drain();
        start_op(1, 16'd65535, 16'd300, 1);
        drain();

        start_op(0, 16'd5, 16'd200, 1);
        drain();
        start_op(0, 16'd0, 16'd9, 1);
        drain();

        start_op(0, 16'd1234, 16'd0, 1);
        drain();
        start_op(0, 16'd100, 16'd10, 1);
        drain();
        start_op(0, 16'd60001, 16'd255, 1);
        drain();

        // start held high while operands move during RUN
        a_start = 1'b1; a_dividend = 16'd1000; a_divisor = 8'd7;
        @(posedge clk); #1;
        sb_a.push_back(mk(16'd1000, 16'd7, cyc + 16));
        a_dividend = 16'd500; a_divisor = 8'd3;
        repeat (18) @(posedge clk);
        #1;
        sb_a.push_back(mk(16'd500, 16'd3, cyc + 16));
        a_dividend = 16'd60000; a_divisor = 8'd255;
        repeat (18) @(posedge clk);
        #1;
        sb_a.push_back(mk(16'd60000, 16'd255, cyc + 16));
        a_start = 1'b0; a_dividend = 16'h1234; a_divisor = 8'h11;
        drain();

        // reset in the middle of an operation
        start_op(0, 16'd1000, 16'd7, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_done", 32'(a_done), 32'd0);
        chk("midrst_quot", 32'(a_quotient), 32'd0);
        chk("midrst_rem", 32'(a_remainder), 32'd0);
        chk("midrst_dbz", 32'(a_dbz), 32'd0);
        repeat (24) @(posedge clk);
        #1;
        start_op(0, 16'd1000, 16'd7, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
